vec_mem_seq: RTL
================

# vec_mem_seq

Sequencer for vector memory transfers (VLOAD/VSTORE) in the multicycle processor's vector extension. The main control FSM starts a transfer with the base address taken from the R2 path. The sequencer then generates the four element addresses and the memory read/write strobes. It steers the data-memory input mux (MemIn) for stores, loads the T0–T3 staging registers for loads, and pulses VRFWrite to commit a loaded vector. It sits between the control FSM and the vector datapath: it consumes the FSM's start request and drives the datapath's memory, T-register and VRF enables.

## Interface
- No parameters.
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clock
- start  in  1  transfer request, sampled only in IDLE
- op  in  1  0 = VLOAD, 1 = VSTORE; latched with start
- base  in  8  element-0 address; latched with start
- stride  in  8  signed element stride; port present only with VEC_MEM_STRIDE_EN
- addr  out  8  data-memory address
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write enable (wren)
- mem_in_sel  out  3  MemIn select: 000–011 = vector lane 0–3, 100 = scalar R1
- vout_sel  out  1  T-mux select: 1 = memory data, 0 = adders
- x1_ld  out  1  load X1 from VRF read port 1
- t_ld  out  4  bit j loads T register j (vdataw[8j+7:8j])
- vrf_write  out  1  VRF write enable
- busy  out  1  high while a transfer is in progress
- done  out  1  one-cycle completion pulse

## Operation
- Element k (k = 0..3) lives at address base + k·stride (stride = 1 without the macro) and maps to vector bits [31−8k : 24−8k], which is lane k and T register 3−k.
- Address arithmetic is 8-bit modulo 256 and wraps silently: 0xFF + 1 = 0x00.
- States and transitions:
  - IDLE → LOAD when start=1 and op=0.
  - IDLE → SFETCH when start=1 and op=1.
  - LOAD issues k = 0..3, then DRAIN → WB → IDLE.
  - SFETCH → STORE issues k = 0..3, then DONE → IDLE.
- In LOAD, mem_read=1 and addr = element k address. Memory has 1-cycle read latency: element k is captured one cycle after its issue with t_ld[3−k]=1. vout_sel=1 for the whole load.
- In SFETCH, x1_ld=1 for one cycle.
- In STORE, mem_write=1, addr = element k address, mem_in_sel=k.
- WB asserts vrf_write=1 and done=1 together. DONE asserts done=1 only.
- Idle outputs:
  - addr = latched address register (0 after reset).
  - mem_in_sel = 100.
  - All strobes, vout_sel, busy and done = 0.
- start while busy=1 is ignored; no queueing. start and done may coincide. A new start is accepted only in the cycle after return to IDLE.
- reset low in any state: IDLE next edge. All outputs take their idle values, with addr = 0 and mem_in_sel = 100. An in-flight load never asserts vrf_write. A store is cut off at the element boundary reached.

## Timing
C0 is the edge that samples start=1 in IDLE.
- VLOAD:
  - C1: addr=base, mem_read.
  - C2–C4: addr=base+k·s, mem_read, t_ld[3]/[2]/[1].
  - C5 (DRAIN): t_ld[0], mem_read=0.
  - C6 (WB): vrf_write, done.
  - busy is high C1–C6. Latency: 6 cycles start-to-done.
- VSTORE:
  - C1: x1_ld.
  - C2–C5: mem_write with addr=base+(k)·s, mem_in_sel=k for k=0..3.
  - C6: done.
  - busy is high C1–C6.
- All outputs are registered or decoded from registered state only. No combinational path from start to any output.

## Configuration
- VEC_MEM_STRIDE_EN defined:
  - stride port exists and is latched at C0.
  - Element address = base + k·stride (8-bit, two's complement, mod 256).
  - stride=0 repeats one address four times.
- Undefined:
  - No stride port; stride fixed at 1.
  - The address register uses an incrementer only.

## Test plan
- Reset: hold reset=0 for 2 cycles with start=1 → busy=0, done=0, addr=0x00, mem_in_sel=100, all strobes 0, throughout and after release.
- VLOAD base=0x10, memory[0x10..0x13]=AA,BB,CC,DD → addr sequence 10,11,12,13 in C1–C4; t_ld=1000,0100,0010,0001 in C2–C5; vdataw=0xAABBCCDD at C6 with vrf_write=done=1.
- VSTORE base=0x40, VRF vector 0x11223344 → mem_write in C2–C5 at 40–43 with mem_in_sel 0–3; memory[0x40..0x43]=11,22,33,44; done at C6.
- Wrap: VLOAD base=0xFE → addresses FE,FF,00,01.
- With VEC_MEM_STRIDE_EN: stride=0xFE (−2), base=0x08 → addresses 08,06,04,02.
- start re-pulsed in C3 of a load → ignored, done exactly once. Then reset=0 in C4 of a second load → no vrf_write, IDLE next cycle.

Source files
------------

// File: rtl/vec_mem_seq.sv
// vec_mem_seq: VLOAD/VSTORE sequencer for the vector extension.
// Generates the four element addresses, memory strobes, MemIn select,
// T-register loads and the VRF commit pulse for one vector transfer.
// Optional feature macro: VEC_MEM_STRIDE_EN (adds a signed 8-bit stride port;
// without it the element stride is fixed at 1).
module vec_mem_seq (
    input  logic                 i_clock,
    input  logic                 i_reset,      // synchronous, active-low
    input  logic                 i_start,
    input  logic                 i_op,         // 0 = VLOAD, 1 = VSTORE
    input  logic [7:0]           i_base,
`ifdef VEC_MEM_STRIDE_EN
    input  logic [7:0]           i_stride,
`endif
    output logic [7:0]           o_addr,
    output logic                 o_mem_read,
    output logic                 o_mem_write,
    output logic [2:0]           o_mem_in_sel,
    output logic                 o_vout_sel,
    output logic                 o_x1_ld,
    output logic [3:0]           o_t_ld,
    output logic                 o_vrf_write,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned ELEM_W = 2;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned TLD_W  = 4;

    localparam logic [ELEM_W-1:0] LAST_ELEM  = 2'd3;
    localparam logic [SEL_W-1:0]  SEL_SCALAR = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_WB     = 3'd3,
        ST_SFETCH = 3'd4,
        ST_STORE  = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    state_t              r_state;
    logic [ELEM_W-1:0]   r_k;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_mem_read;
    logic                r_mem_write;
    logic [SEL_W-1:0]    r_mem_in_sel;
    logic                r_vout_sel;
    logic                r_x1_ld;
    logic [TLD_W-1:0]    r_t_ld;
    logic                r_vrf_write;
    logic                r_busy;
    logic                r_done;

    state_t              w_state_nxt;
    logic [ELEM_W-1:0]   w_k_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [ADDR_W-1:0]   w_addr_step;
    logic                w_mem_read_nxt;
    logic                w_mem_write_nxt;
    logic [SEL_W-1:0]    w_mem_in_sel_nxt;
    logic                w_vout_sel_nxt;
    logic                w_x1_ld_nxt;
    logic [TLD_W-1:0]    w_t_ld_nxt;
    logic                w_vrf_write_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;

`ifdef VEC_MEM_STRIDE_EN
    logic [ADDR_W-1:0]   r_stride;

    // Stride is captured together with start so a transfer uses one stride
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_stride <= '0;
        end else if (r_state == ST_IDLE && i_start) begin
            r_stride <= i_stride;
        end
    end

    // Next element address: two's-complement stride, wraps mod 256
    always_comb begin
        w_addr_step = ADDR_W'(r_addr + r_stride);
    end
`else
    // Next element address: unit stride incrementer, wraps mod 256
    always_comb begin
        w_addr_step = ADDR_W'(r_addr + ADDR_W'(1));
    end
`endif

    // Next-state, element counter and address register update
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_addr_nxt  = r_addr;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = i_op ? ST_SFETCH : ST_LOAD;
                    w_k_nxt     = '0;
                    w_addr_nxt  = i_base;
                end
            end
            ST_LOAD: begin
                if (r_k == LAST_ELEM) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_k_nxt    = ELEM_W'(r_k + ELEM_W'(1));
                    w_addr_nxt = w_addr_step;
                end
            end
            ST_DRAIN:  w_state_nxt = ST_WB;
            ST_WB:     w_state_nxt = ST_IDLE;
            ST_SFETCH: begin
                w_state_nxt = ST_STORE;
                w_k_nxt     = '0;
            end
            ST_STORE: begin
                if (r_k == LAST_ELEM) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_k_nxt    = ELEM_W'(r_k + ELEM_W'(1));
                    w_addr_nxt = w_addr_step;
                end
            end
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Output values for the upcoming cycle, decoded from next state/element
    always_comb begin
        w_mem_read_nxt   = 1'b0;
        w_mem_write_nxt  = 1'b0;
        w_mem_in_sel_nxt = SEL_SCALAR;
        w_vout_sel_nxt   = 1'b0;
        w_x1_ld_nxt      = 1'b0;
        w_t_ld_nxt       = '0;
        w_vrf_write_nxt  = 1'b0;
        w_busy_nxt       = 1'b0;
        w_done_nxt       = 1'b0;
        case (w_state_nxt)
            ST_LOAD: begin
                w_mem_read_nxt = 1'b1;
                w_vout_sel_nxt = 1'b1;
                w_busy_nxt     = 1'b1;
                // Data issued for element k-1 returns now; it goes to T(3-(k-1))
                case (w_k_nxt)
                    2'd1:    w_t_ld_nxt = 4'b1000;
                    2'd2:    w_t_ld_nxt = 4'b0100;
                    2'd3:    w_t_ld_nxt = 4'b0010;
                    default: w_t_ld_nxt = 4'b0000;
                endcase
            end
            ST_DRAIN: begin
                w_vout_sel_nxt = 1'b1;
                w_t_ld_nxt     = 4'b0001;
                w_busy_nxt     = 1'b1;
            end
            ST_WB: begin
                w_vout_sel_nxt  = 1'b1;
                w_vrf_write_nxt = 1'b1;
                w_done_nxt      = 1'b1;
                w_busy_nxt      = 1'b1;
            end
            ST_SFETCH: begin
                w_x1_ld_nxt = 1'b1;
                w_busy_nxt  = 1'b1;
            end
            ST_STORE: begin
                w_mem_write_nxt  = 1'b1;
                w_mem_in_sel_nxt = {1'b0, w_k_nxt};
                w_busy_nxt       = 1'b1;
            end
            ST_DONE: begin
                w_done_nxt = 1'b1;
                w_busy_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    // State, counter, address and registered outputs
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state      <= ST_IDLE;
            r_k          <= '0;
            r_addr       <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_in_sel <= SEL_SCALAR;
            r_vout_sel   <= 1'b0;
            r_x1_ld      <= 1'b0;
            r_t_ld       <= '0;
            r_vrf_write  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_k          <= w_k_nxt;
            r_addr       <= w_addr_nxt;
            r_mem_read   <= w_mem_read_nxt;
            r_mem_write  <= w_mem_write_nxt;
            r_mem_in_sel <= w_mem_in_sel_nxt;
            r_vout_sel   <= w_vout_sel_nxt;
            r_x1_ld      <= w_x1_ld_nxt;
            r_t_ld       <= w_t_ld_nxt;
            r_vrf_write  <= w_vrf_write_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign o_addr       = r_addr;
    assign o_mem_read   = r_mem_read;
    assign o_mem_write  = r_mem_write;
    assign o_mem_in_sel = r_mem_in_sel;
    assign o_vout_sel   = r_vout_sel;
    assign o_x1_ld      = r_x1_ld;
    assign o_t_ld       = r_t_ld;
    assign o_vrf_write  = r_vrf_write;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

endmodule
